// File: rtl/alu_bist_driver.sv
// BIST initiator for the 5-bit-opcode ALU: sweeps every opcode with LFSR operands,
// folds Y/zero into a 32-bit MISR signature and flags pass against a golden value.
module alu_bist_driver #(
  parameter logic [4:0]  OP_LAST    = 5'd9,
  parameter int unsigned VECTORS    = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2025,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_y,
  input  logic        alu_zero
);

  localparam int unsigned    VEC_W    = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VECTORS - 1);
  localparam logic [31:0]    SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0]    B_XOR    = 32'h5A5A_5A5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_e;

  // Shared LFSR / MISR shift: taps 31, 21, 1, 0 fed back into bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      lfsr_a_q, lfsr_a_d;
  logic [31:0]      lfsr_b_q, lfsr_b_d;
  logic [31:0]      sig_q, sig_d;
  logic [4:0]       op_cnt_q, op_cnt_d;
  logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_a_q  <= 32'h0;
      lfsr_b_q  <= 32'h0;
      sig_q     <= 32'h0;
      op_cnt_q  <= 5'd0;
      vec_cnt_q <= '0;
      alu_a_q   <= 32'h0;
      alu_b_q   <= 32'h0;
      alu_op_q  <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      sig_q     <= sig_d;
      op_cnt_q  <= op_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    sig_d     = sig_q;
    op_cnt_d  = op_cnt_q;
    vec_cnt_d = vec_cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    pass_d    = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        lfsr_a_d  = SEED_EFF;
        lfsr_b_d  = SEED_EFF ^ B_XOR;
        sig_d     = 32'h0;
        op_cnt_d  = 5'd0;
        vec_cnt_d = '0;
        pass_d    = 1'b0;
        state_d   = S_APPLY;
      end
      S_APPLY: begin
        // Vector 0 drives A==B so SUB/XOR exercise the zero flag
        alu_op_d = op_cnt_q;
        alu_a_d  = lfsr_a_q;
        alu_b_d  = (vec_cnt_q == '0) ? lfsr_a_q : lfsr_b_q;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        sig_d    = lfsr_step(sig_q) ^ alu_y ^ {31'b0, alu_zero};
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        state_d  = S_APPLY;
        if (vec_cnt_q == VEC_LAST) begin
          vec_cnt_d = '0;
          op_cnt_d  = op_cnt_q + 5'd1;
          if (op_cnt_q == OP_LAST) begin
            state_d  = S_DONE;
            pass_d   = (sig_d == GOLDEN_SIG);
            alu_a_d  = 32'h0;
            alu_b_d  = 32'h0;
            alu_op_d = 5'd0;
          end
        end else begin
          vec_cnt_d = vec_cnt_q + VEC_W'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_APPLY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: behavioural ALU plus a loop-level signature/operand model.
module tb_alu_bist_driver;

  localparam logic [4:0]  OP_LAST = 5'd9;
  localparam int          VECTORS = 16;
  localparam int          N       = VECTORS * (int'(OP_LAST) + 1);
  localparam logic [31:0] SEED    = 32'hACE1_2025;

  function automatic logic [31:0] step32(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << b[4:0];
      5'd6:    return a >> b[4:0];
      5'd7:    return (a < b) ? 32'h1 : 32'h0;
      5'd8:    return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // Whole-run signature; fault forces Y[7] low on the wire back to the BIST
  function automatic logic [31:0] model_sig(input logic fault);
    logic [31:0] la, lb, sig, y, yw;
    logic        z;
    la  = SEED;
    lb  = SEED ^ 32'h5A5A_5A5A;
    sig = 32'h0;
    for (int k = 0; k < N; k++) begin
      y   = alu_model(la, ((k % VECTORS) == 0) ? la : lb, 5'(k / VECTORS));
      z   = (y == 32'h0);
      yw  = fault ? (y & ~32'h80) : y;
      sig = step32(sig) ^ yw ^ {31'b0, z};
      la  = step32(la);
      lb  = step32(lb);
    end
    return sig;
  endfunction

  localparam logic [31:0] EXP_SIG = model_sig(1'b0);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [31:0] signature, alu_a, alu_b, alu_y, y_true;
  logic [4:0]  alu_op;
  logic        alu_zero;
  logic        fault_en;

  logic [31:0] exp_a [N];
  logic [31:0] exp_b [N];
  logic [4:0]  exp_op[N];
  logic [31:0] fault_sig;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    y_true   = alu_model(alu_a, alu_b, alu_op);
    alu_zero = (y_true == 32'h0);
    alu_y    = fault_en ? (y_true & ~32'h80) : y_true;
  end

  alu_bist_driver #(
    .OP_LAST   (OP_LAST),
    .VECTORS   (VECTORS),
    .LFSR_SEED (SEED),
    .GOLDEN_SIG(EXP_SIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .signature(signature),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_zero (alu_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build_vectors();
    logic [31:0] la, lb;
    la = SEED;
    lb = SEED ^ 32'h5A5A_5A5A;
    for (int k = 0; k < N; k++) begin
      exp_op[k] = 5'(k / VECTORS);
      exp_a[k]  = la;
      exp_b[k]  = ((k % VECTORS) == 0) ? la : lb;
      la = step32(la);
      lb = step32(lb);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_pass"}, 32'(pass), 32'h0);
    check({tag, "_sig"}, signature, 32'h0);
    check({tag, "_a"}, alu_a, 32'h0);
    check({tag, "_b"}, alu_b, 32'h0);
    check({tag, "_op"}, 32'(alu_op), 32'h0);
  endtask

  // One run from a start pulse; rst_at/poke_at of 0 disable the abort / extra start
  task automatic run_test(input string tag, input int rst_at, input int poke_at,
                          input logic fault);
    logic [31:0] exp_sig;
    int busy_cnt, done_cyc, idx;
    fault_en = fault;
    exp_sig  = fault ? fault_sig : EXP_SIG;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 2 * N + 8; c++) begin
      if (c == 1) begin
        check({tag, "_busy_c1"}, 32'(busy), 32'h1);
        check({tag, "_done_c1"}, 32'(done), 32'h0);
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check_idle_outputs({tag, "_after_rst"});
        rst = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      if (c >= 3 && (c % 2) == 1 && (c - 3) / 2 < N) begin
        idx = (c - 3) / 2;
        if (alu_op !== exp_op[idx]) check({tag, "_vec_op"}, 32'(alu_op), 32'(exp_op[idx]));
        if (alu_a !== exp_a[idx])   check({tag, "_vec_a"}, alu_a, exp_a[idx]);
        if (alu_b !== exp_b[idx])   check({tag, "_vec_b"}, alu_b, exp_b[idx]);
        if (idx < 2 || idx == N - 1) begin
          check({tag, "_op_v"}, 32'(alu_op), 32'(exp_op[idx]));
          check({tag, "_a_v"}, alu_a, exp_a[idx]);
          check({tag, "_b_v"}, alu_b, exp_b[idx]);
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      start = (c == poke_at);
      rst   = (c == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(2 * N + 1));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(2 * N + 2));
    check({tag, "_pass"}, 32'(pass), 32'(exp_sig == EXP_SIG));
    check({tag, "_sig"}, signature, exp_sig);
    check({tag, "_alu_a_zero"}, alu_a, 32'h0);
    check({tag, "_alu_op_zero"}, 32'(alu_op), 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    fault_en = 1'b0;
    build_vectors();
    fault_sig = model_sig(1'b1);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    check("first_vec_b", exp_b[1], step32(SEED ^ 32'h5A5A_5A5A));
    run_test("run1", 0, 0, 1'b0);
    run_test("abort", 100, 0, 1'b0);
    run_test("after_abort", 0, 0, 1'b0);
    run_test("poke50", 0, 50, 1'b0);
    run_test("restart", 0, 0, 1'b0);
    run_test("fault", 0, 0, 1'b1);
    check("fault_sig_differs", 32'(signature != EXP_SIG), 32'h1);
    run_test("poke_rand", 0, $urandom_range(2, 2 * N), 1'b0);
    run_test("abort_rand", $urandom_range(2, 2 * N), 0, 1'b0);
    run_test("final", 0, 0, 1'b0);

    // start held under rst stays idle; releasing rst with start high loads next edge
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_start_busy", 32'(busy), 32'h0);
      check("rst_start_done", 32'(done), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("release_load_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("final_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
